// File: rtl/hc138_scan_pkg.sv
// hc138_scan_pkg: shared definitions for the HC138 scan sequencer.
//   - Wishbone register offsets (wbs_adr_i[3:2])
//   - CTRL / STATUS bit positions
//   - decoder G encodings for drive and blank
//   - scan FSM state type
//   - byte_merge(): byte-lane write helper for 32-bit Wishbone writes
package hc138_scan_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DWELL  = 2'd1;
    localparam logic [1:0] REG_MASK   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_ONESHOT = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;

    localparam int unsigned STAT_BUSY     = 3;
    localparam int unsigned STAT_FDONE    = 4;
    localparam int unsigned STAT_FCNT_LSB = 8;

    localparam logic [2:0] G_DRIVE = 3'b100;
    localparam logic [2:0] G_BLANK = 3'b000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBlank = 2'd1,
        StDrive = 2'd2
    } scan_state_e;

    // Replace the byte lanes of old_val selected by sel with those of new_val.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hc138_scan_next_row.sv
// hc138_scan_next_row: combinational row selector for the scan sequencer.
// Ports:
//   mask [7:0]  row enable bits
//   cur  [2:0]  row currently selected
//   next [2:0]  lowest set mask bit strictly above cur, else lowest set bit
//   wrap        no set bit above cur, so next wrapped to the lowest set bit
//   none        mask is empty; next/wrap are meaningless
module hc138_scan_next_row (
    input  logic [7:0] mask,
    input  logic [2:0] cur,
    output logic [2:0] next,
    output logic       wrap,
    output logic       none
);

    logic       found_above;
    logic [2:0] above;
    logic [2:0] lowest;

    // Scan downwards so the last hit in each category is the lowest one.
    always_comb begin
        found_above = 1'b0;
        above       = 3'd0;
        lowest      = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                lowest = 3'(i);
                if (i > int'(cur)) begin
                    above       = 3'(i);
                    found_above = 1'b1;
                end
            end
        end
    end

    assign none = (mask == 8'd0);
    assign wrap = !found_above && !none;
    assign next = found_above ? above : lowest;

endmodule

// File: rtl/hc138_scan_sequencer.sv
// hc138_scan_sequencer: Wishbone-programmable scan sequencer driving the A/G inputs of the
// on-chip 3-to-8 decoder. Steps through the rows enabled in MASK, blanking BLANK_CYC cycles
// before each row and driving it for max(DWELL,1) cycles; counts frames, raises FDONE/IRQ.
// Optional feature: define SCAN_SEQ_FRAME_IRQ_EN to enable irq_o and CTRL.IRQ_EN; otherwise
// irq_o is tied low and CTRL.IRQ_EN reads 0.
// Ports:
//   wb_clk_i, wb_rst_n_i            clock, asynchronous active-low reset
//   wbs_stb/cyc/we/sel/adr/dat_i    Wishbone slave request (adr[3:2] selects register)
//   wbs_ack_o, wbs_dat_o            registered single-cycle ack and read data
//   scan_a_o                        decoder A (row index)
//   scan_g_o                        decoder G (3'b100 drive, 3'b000 blank)
//   irq_o                           level IRQ = STATUS.FDONE & CTRL.IRQ_EN
module hc138_scan_sequencer
    import hc138_scan_pkg::*;
#(
    parameter int unsigned DW_W      = 16,
    parameter int unsigned BLANK_CYC = 2,
    parameter int unsigned FCNT_W    = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [2:0]  scan_a_o,
    output logic [2:0]  scan_g_o,
    output logic        irq_o
);

    localparam int unsigned BC_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BC_W-1:0] BLANK_LOAD = BC_W'(BLANK_CYC - 1);

    scan_state_e     state_q, state_d;
    logic [2:0]      row_q, row_d;
    logic [BC_W-1:0] blank_cnt_q, blank_cnt_d;
    logic [DW_W-1:0] dwell_cnt_q, dwell_cnt_d;

    logic              en_q, en_d, en_eff;
    logic              oneshot_q, oneshot_d;
    logic              irq_en_q, irq_en_d;
    logic [DW_W-1:0]   dwell_q, dwell_d, dwell_load;
    logic [7:0]        mask_q, mask_d;
    logic              fdone_q, fdone_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    logic        ack_q;
    logic [31:0] dat_q, rdata, dwell_merged;
    logic        req, wr_ctrl, wr_dwell, wr_mask, w1c_fdone, frame_end;
    logic [2:0]  nr_cur, nr_next;
    logic        nr_wrap, nr_none;
    logic        unused_bits;

    // Wishbone decode: a request is only accepted while ack is low, so each access takes
    // at least two cycles and every request produces exactly one ack.
    assign req       = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wr_ctrl   = req & wbs_we_i & (wbs_adr_i[3:2] == REG_CTRL) & wbs_sel_i[0];
    assign wr_dwell  = req & wbs_we_i & (wbs_adr_i[3:2] == REG_DWELL);
    assign wr_mask   = req & wbs_we_i & (wbs_adr_i[3:2] == REG_MASK) & wbs_sel_i[0];
    assign w1c_fdone = req & wbs_we_i & (wbs_adr_i[3:2] == REG_STATUS) & wbs_sel_i[0]
                       & wbs_dat_i[STAT_FDONE];

    assign dwell_merged = byte_merge(32'(dwell_q), wbs_dat_i, wbs_sel_i);
    assign unused_bits  = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], dwell_merged};

    // The FSM sees an EN write in the same cycle it lands, so clearing EN stops the scan
    // on the ack edge rather than one cycle later.
    assign en_eff = wr_ctrl ? wbs_dat_i[CTRL_EN] : en_q;

    // From IDLE, asking for the row above 7 yields the lowest set bit.
    assign nr_cur     = (state_q == StIdle) ? 3'd7 : row_q;
    assign dwell_load = (dwell_q == '0) ? '0 : dwell_q - DW_W'(1);

    hc138_scan_next_row u_next_row (
        .mask (mask_q),
        .cur  (nr_cur),
        .next (nr_next),
        .wrap (nr_wrap),
        .none (nr_none)
    );

    // Scan FSM next state.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        blank_cnt_d = blank_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        frame_end   = 1'b0;
        case (state_q)
            StIdle: begin
                if (en_eff && !nr_none) begin
                    row_d       = nr_next;
                    blank_cnt_d = BLANK_LOAD;
                    state_d     = StBlank;
                end
            end
            StBlank: begin
                if (!en_eff) begin
                    state_d = StIdle;
                end else if (blank_cnt_q == '0) begin
                    dwell_cnt_d = dwell_load;
                    state_d     = StDrive;
                end else begin
                    blank_cnt_d = blank_cnt_q - BC_W'(1);
                end
            end
            StDrive: begin
                if (!en_eff) begin
                    state_d = StIdle;
                end else if (dwell_cnt_q != '0) begin
                    dwell_cnt_d = dwell_cnt_q - DW_W'(1);
                end else if (nr_none) begin
                    state_d = StIdle;
                end else begin
                    frame_end = nr_wrap;
                    if (nr_wrap && oneshot_q) begin
                        state_d = StIdle;
                    end else begin
                        row_d       = nr_next;
                        blank_cnt_d = BLANK_LOAD;
                        state_d     = StBlank;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Register file next state.
    always_comb begin
        oneshot_d = oneshot_q;
        irq_en_d  = irq_en_q;
        mask_d    = mask_q;
        dwell_d   = dwell_q;
        if (wr_ctrl) begin
            oneshot_d = wbs_dat_i[CTRL_ONESHOT];
`ifdef SCAN_SEQ_FRAME_IRQ_EN
            irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
`endif
        end
        if (wr_mask) begin
            mask_d = wbs_dat_i[7:0];
        end
        if (wr_dwell) begin
            dwell_d = dwell_merged[DW_W-1:0];
        end
        en_d    = en_eff & ~(frame_end & oneshot_q);
        // A set from frame end wins over a simultaneous write-1-to-clear.
        fdone_d = frame_end | (fdone_q & ~w1c_fdone);
        fcnt_d  = frame_end ? fcnt_q + FCNT_W'(1) : fcnt_q;
    end

    // Read mux; sampled in the request cycle and presented with ack.
    always_comb begin
        rdata = '0;
        case (wbs_adr_i[3:2])
            REG_CTRL: begin
                rdata[CTRL_EN]      = en_q;
                rdata[CTRL_ONESHOT] = oneshot_q;
                rdata[CTRL_IRQ_EN]  = irq_en_q;
            end
            REG_DWELL: rdata[DW_W-1:0] = dwell_q;
            REG_MASK:  rdata[7:0]      = mask_q;
            REG_STATUS: begin
                rdata[2:0]                     = row_q;
                rdata[STAT_BUSY]               = (state_q != StIdle);
                rdata[STAT_FDONE]              = fdone_q;
                rdata[STAT_FCNT_LSB +: FCNT_W] = fcnt_q;
            end
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= StIdle;
            row_q       <= 3'd0;
            blank_cnt_q <= '0;
            dwell_cnt_q <= '0;
            en_q        <= 1'b0;
            oneshot_q   <= 1'b0;
            irq_en_q    <= 1'b0;
            dwell_q     <= DW_W'(1);
            mask_q      <= 8'd0;
            fdone_q     <= 1'b0;
            fcnt_q      <= '0;
            ack_q       <= 1'b0;
            dat_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            blank_cnt_q <= blank_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            en_q        <= en_d;
            oneshot_q   <= oneshot_d;
            irq_en_q    <= irq_en_d;
            dwell_q     <= dwell_d;
            mask_q      <= mask_d;
            fdone_q     <= fdone_d;
            fcnt_q      <= fcnt_d;
            ack_q       <= req;
            dat_q       <= req ? rdata : 32'd0;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign scan_a_o  = row_q;
    assign scan_g_o  = (state_q == StDrive) ? G_DRIVE : G_BLANK;

`ifdef SCAN_SEQ_FRAME_IRQ_EN
    assign irq_o = fdone_q & irq_en_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_hc138_scan_sequencer.sv
module tb_hc138_scan_sequencer;

`ifdef SCAN_SEQ_FRAME_IRQ_EN
    localparam bit IrqBuild = 1'b1;
`else
    localparam bit IrqBuild = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [2:0]  a, g;
    logic        irq;

    hc138_scan_sequencer dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .scan_a_o   (a),
        .scan_g_o   (g),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int row;
        int len;
        int blank;   // -1: not checked
    } seg_t;

    typedef struct {
        bit          is_write;
        logic [31:0] data;
        logic [31:0] mask;
        string       name;
    } wb_exp_t;

    seg_t    seg_q[$];
    wb_exp_t wb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_fcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model helpers ----------------
    function automatic int popc(input logic [7:0] m);
        int c = 0;
        for (int i = 0; i < 8; i++) if (m[i]) c++;
        return c;
    endfunction

    // n-th enabled row in ascending order
    function automatic int nth_row(input logic [7:0] m, input int n);
        int k = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                if (k == n) return i;
                k++;
            end
        end
        return -1;
    endfunction

    function automatic logic [31:0] status_val(input int row, input bit busy, input bit fdone,
                                               input int fcnt);
        logic [31:0] v;
        v       = 32'd0;
        v[2:0]  = 3'(row);
        v[3]    = busy;
        v[4]    = fdone;
        v[15:8] = 8'(fcnt);
        return v;
    endfunction

    function automatic int eff_dwell(input int dw);
        return (dw == 0) ? 1 : dw;
    endfunction

    task automatic push_seg(input int row, input int len, input int blank);
        seg_t s;
        s.row = row;
        s.len = len;
        s.blank = blank;
        seg_q.push_back(s);
    endtask

    // ---------------- Wishbone driver ----------------
    task automatic wb_xfer(input bit w, input int reg_idx, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] exp, input logic [31:0] msk,
                           input string name);
        wb_exp_t e;
        e.is_write = w;
        e.data = exp;
        e.mask = msk;
        e.name = name;
        wb_q.push_back(e);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; sel = s;
        adr = 32'(reg_idx) << 2;
        wdat = d;
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input int reg_idx, input logic [31:0] d);
        wb_xfer(1'b1, reg_idx, d, 4'hF, 32'd0, 32'd0, "write");
    endtask

    task automatic wb_read(input int reg_idx, input logic [31:0] exp, input logic [31:0] msk,
                           input string name);
        wb_xfer(1'b0, reg_idx, 32'd0, 4'hF, exp, msk, name);
    endtask

    // ---------------- bounded waits ----------------
    task automatic wait_q_le(input int k);
        int c = 0;
        while (seg_q.size() > k && c < 3000) begin
            @(posedge clk);
            c++;
        end
        n_checks++;
        if (seg_q.size() > k) begin
            n_fail++;
            $display("FAIL seg_wait: %0d rows outstanding, required <= %0d", seg_q.size(), k);
            seg_q.delete();
        end
    endtask

    task automatic wait_drive(input int row);
        int c = 0;
        @(negedge clk);
        while (!(g === 3'b100 && (row < 0 || int'(a) == row)) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (c >= 3000) begin
            n_fail++;
            $display("FAIL drive_wait: row %0d never driven, last a=%0d g=%b", row, a, g);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    bit in_seg = 1'b0;
    int cur_row, cur_len, seg_gap, gap = -1;
    bit a_moved;

    initial begin
        wb_exp_t e;
        seg_t    s;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_seg = 1'b0;
                gap = -1;
            end else begin
                if (ack === 1'b1) begin
                    if (wb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL wb_ack: got unexpected ack, required none");
                    end else begin
                        e = wb_q.pop_front();
                        if (!e.is_write) check(e.name, rdat & e.mask, e.data & e.mask);
                    end
                end
                if (g === 3'b100) begin
                    if (!in_seg) begin
                        in_seg = 1'b1;
                        cur_row = int'(a);
                        cur_len = 1;
                        seg_gap = gap;
                        a_moved = 1'b0;
                    end else begin
                        cur_len++;
                        if (int'(a) != cur_row) a_moved = 1'b1;
                    end
                end else begin
                    if (g !== 3'b000) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL g_value: got %b, required 000 or 100", g);
                    end
                    if (in_seg) begin
                        in_seg = 1'b0;
                        if (seg_q.size() > 0) begin
                            s = seg_q.pop_front();
                            check("row_index", 32'(cur_row), 32'(s.row));
                            check("drive_len", 32'(cur_len), 32'(s.len));
                            check("a_stable", 32'(a_moved), 32'd0);
                            if (s.blank >= 0) check("blank_len", 32'(seg_gap), 32'(s.blank));
                        end
                        gap = 1;
                    end else if (gap >= 0) begin
                        gap++;
                    end
                end
            end
        end
    end

    // Continuous scan for nsegs rows, then stop and check STATUS.
    task automatic run_scan(input logic [7:0] m, input int dw, input int nsegs,
                            input bit mid_fdone);
        int p, frames, nxt;
        p = popc(m);
        frames = 0;
        for (int i = 0; i < nsegs; i++) begin
            push_seg(nth_row(m, i % p), eff_dwell(dw), (i == 0) ? -1 : 2);
            if (i % p == p - 1) frames++;
        end
        nxt = nth_row(m, nsegs % p);
        wb_write(1, 32'(dw));
        wb_write(2, 32'(m));
        wb_write(0, 32'h1);
        if (mid_fdone) begin
            wait_q_le(nsegs - p);
            wb_read(3, 32'h10, 32'h10, "fdone_after_frame");
        end
        wait_q_le(0);
        wb_write(0, 32'h0);
        exp_fcnt = (exp_fcnt + frames) % 256;
        wb_read(3, status_val(nxt, 1'b0, 1'b1, exp_fcnt), 32'hFFFF_FFFF, "status_after_run");
        wb_write(3, 32'h10);
        wb_read(3, status_val(nxt, 1'b0, 1'b0, exp_fcnt), 32'hFFFF_FFFF, "status_w1c");
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m;
        int dw;
        rst_n = 1'b0;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; wdat = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", 32'(a), 32'd0);
        check("reset_g", 32'(g), 32'd0);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_dat", rdat, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;

        wb_read(0, 32'd0, 32'hFFFF_FFFF, "reset_ctrl");
        wb_read(1, 32'd1, 32'hFFFF_FFFF, "reset_dwell");
        wb_read(2, 32'd0, 32'hFFFF_FFFF, "reset_mask");
        wb_read(3, 32'd0, 32'hFFFF_FFFF, "reset_status");
        wb_xfer(1'b1, 1, 32'h0000_0200, 4'b0010, 32'd0, 32'd0, "write");
        wb_read(1, 32'h0000_0201, 32'hFFFF_FFFF, "dwell_byte_sel");

        // 1: all rows, dwell 3
        run_scan(8'hFF, 3, 8, 1'b0);
        // 2: rows 2/5, dwell 0 acts as 1
        run_scan(8'h24, 0, 5, 1'b1);

        // 3: oneshot with IRQ enable, rows 0 and 7 then idle
        push_seg(0, 2, -1);
        push_seg(7, 2, 2);
        wb_write(1, 32'd2);
        wb_write(2, 32'h81);
        wb_write(0, 32'h7);
        wait_q_le(0);
        repeat (2) @(posedge clk);
        wb_read(0, IrqBuild ? 32'h6 : 32'h2, 32'hFFFF_FFFF, "oneshot_ctrl");
        @(negedge clk);
        check("oneshot_irq", 32'(irq), 32'(IrqBuild));
        exp_fcnt = (exp_fcnt + 1) % 256;
        wb_read(3, status_val(0, 1'b0, 1'b1, exp_fcnt), 32'hFFFF_FFF8, "oneshot_status");
        wb_write(3, 32'h10);
        @(negedge clk);
        check("irq_cleared", 32'(irq), 32'd0);
        wb_read(3, status_val(0, 1'b0, 1'b0, exp_fcnt), 32'hFFFF_FFF8, "oneshot_w1c");

        // 4: clear EN while row 3 drives
        for (int r = 0; r < 3; r++) push_seg(r, 20, (r == 0) ? -1 : 2);
        wb_write(1, 32'd20);
        wb_write(2, 32'hFF);
        wb_write(0, 32'h1);
        wait_q_le(0);
        wait_drive(3);
        wb_write(0, 32'h0);
        @(negedge clk);
        check("en_clear_g", 32'(g), 32'd0);
        check("en_clear_a", 32'(a), 32'd3);
        wb_read(3, status_val(3, 1'b0, 1'b0, exp_fcnt), 32'hFFFF_FFFF, "en_clear_status");

        // 5: MASK shrinks to 0x01 while row 1 drives
        push_seg(0, 10, -1);
        push_seg(1, 10, 2);
        push_seg(0, 10, 2);
        push_seg(0, 10, 2);
        wb_write(1, 32'd10);
        wb_write(2, 32'h0F);
        wb_write(0, 32'h1);
        wait_q_le(3);
        wait_drive(1);
        wb_write(2, 32'h01);
        wait_q_le(0);
        wb_write(0, 32'h0);
        exp_fcnt = (exp_fcnt + 3) % 256;
        wb_read(3, status_val(0, 1'b0, 1'b1, exp_fcnt), 32'hFFFF_FFFF, "mask_change_status");
        wb_write(3, 32'h10);

        // randomized masks and dwell values
        for (int t = 0; t < 4; t++) begin
            m  = 8'($urandom_range(1, 255));
            dw = int'($urandom_range(0, 4));
            run_scan(m, dw, 2 * popc(m) + 1, 1'b0);
        end

        // 6: asynchronous reset mid-drive with an ack in flight
        wb_write(1, 32'd5);
        wb_write(2, 32'hFF);
        wb_write(0, 32'h1);
        wait_drive(2);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_g", 32'(g), 32'd0);
        check("rst_mid_a", 32'(a), 32'd0);
        check("rst_mid_ack", 32'(ack), 32'd0);
        stb = 1'b0; cyc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_fcnt = 0;
        wb_read(0, 32'd0, 32'hFFFF_FFFF, "rst_mid_ctrl");
        wb_read(1, 32'd1, 32'hFFFF_FFFF, "rst_mid_dwell");
        wb_read(2, 32'd0, 32'hFFFF_FFFF, "rst_mid_mask");
        wb_read(3, 32'd0, 32'hFFFF_FFFF, "rst_mid_status");
        repeat (3) @(posedge clk);
        n_checks++;
        if (wb_q.size() != 0 || seg_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d wb / %0d rows pending, required 0",
                     wb_q.size(), seg_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
